// File: rtl/rx_handshake.sv
`default_nettype none
// ============================================================================
// Module   : rx_handshake
// Brief    : RX-side valid/ready handshake into a DEPTH-entry FIFO, drained
//            by the router core with a pop pulse. Optional even-parity
//            filter on incoming words when RX_PARITY_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module rx_handshake #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int PTR_W  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] RX_Data,
    input  logic              RX_Data_Valid,
    output logic              RX_Data_Ready,
    input  logic              rc_took_data,
    output logic              rx_has_data,
    output logic [DATA_W-1:0] rx_data,
    output logic [PTR_W:0]    rx_count,
    output logic              rx_underflow
`ifdef RX_PARITY_EN
    ,
    input  logic              RX_Parity,
    output logic              rx_parity_err
`endif
);

    localparam logic [PTR_W:0]   c_FULL  = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   c_ONE   = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] c_P_ONE = PTR_W'(1);

    typedef enum logic [1:0] {
        ST_RST = 2'b00,
        ST_RUN = 2'b01
    } state_t;

    state_t            r_state;
    logic              r_ready;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W:0]    r_count;
    logic              r_underflow;
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              w_accept;
    logic              w_par_ok;
    logic              w_push;
    logic              w_pop;
    logic [PTR_W:0]    w_count_nxt;

    assign w_accept = RX_Data_Valid & r_ready;

`ifdef RX_PARITY_EN
    logic r_parity_err;

    assign w_par_ok      = ~(^{RX_Data, RX_Parity});
    assign rx_parity_err = r_parity_err;

    // A bad word is still handshaken away from the RX unit, only the push is suppressed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_parity_err <= 1'b0;
        end else if (w_accept && !w_par_ok) begin
            r_parity_err <= 1'b1;
        end
    end
`else
    assign w_par_ok = 1'b1;
`endif

    assign w_push = w_accept & w_par_ok;
    assign w_pop  = rc_took_data & (r_count != '0);

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + c_ONE;
            2'b01:   w_count_nxt = r_count - c_ONE;
            default: w_count_nxt = r_count;
        endcase
    end

    // Ready is registered from the next count so it tracks full without a comb path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RST;
            r_ready <= 1'b0;
        end else begin
            case (r_state)
                ST_RST: begin
                    r_state <= ST_RUN;
                    r_ready <= (w_count_nxt != c_FULL);
                end
                ST_RUN: begin
                    r_state <= ST_RUN;
                    r_ready <= (w_count_nxt != c_FULL);
                end
                default: begin
                    r_state <= ST_RST;
                    r_ready <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_underflow <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= RX_Data;
                r_wr_ptr        <= r_wr_ptr + c_P_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_P_ONE;
            end
            if (rc_took_data && (r_count == '0)) begin
                r_underflow <= 1'b1;
            end
            r_count <= w_count_nxt;
        end
    end

    assign RX_Data_Ready = r_ready;
    assign rx_has_data   = (r_count != '0);
    assign rx_data       = r_mem[r_rd_ptr];
    assign rx_count      = r_count;
    assign rx_underflow  = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_rx_handshake.sv
`default_nettype none
// ============================================================================
// Module   : tb_rx_handshake
// Brief    : Directed bench for rx_handshake; inputs change and outputs are
//            sampled on the falling edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rx_handshake;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;
    localparam int PTR_W  = 2;

    logic              clk;
    logic              rst_n;
    logic [DATA_W-1:0] RX_Data;
    logic              RX_Data_Valid;
    logic              RX_Data_Ready;
    logic              rc_took_data;
    logic              rx_has_data;
    logic [DATA_W-1:0] rx_data;
    logic [PTR_W:0]    rx_count;
    logic              rx_underflow;
`ifdef RX_PARITY_EN
    logic              RX_Parity;
    logic              rx_parity_err;
`endif

    int n_vec  = 0;
    int n_miss = 0;

    rx_handshake #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .PTR_W  (PTR_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .RX_Data       (RX_Data),
        .RX_Data_Valid (RX_Data_Valid),
        .RX_Data_Ready (RX_Data_Ready),
        .rc_took_data  (rc_took_data),
        .rx_has_data   (rx_has_data),
        .rx_data       (rx_data),
        .rx_count      (rx_count),
        .rx_underflow  (rx_underflow)
`ifdef RX_PARITY_EN
        ,
        .RX_Parity     (RX_Parity),
        .rx_parity_err (rx_parity_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        n_miss++;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $fatal(1);
    end

    initial begin
        logic [7:0] exp_q [4];
        rst_n         = 1'b0;
        RX_Data       = '0;
        RX_Data_Valid = 1'b0;
        rc_took_data  = 1'b0;
`ifdef RX_PARITY_EN
        RX_Parity     = 1'b0;
`endif
        cyc(); cyc();
        chk("rst_ready", 32'(RX_Data_Ready), 32'd0);
        chk("rst_has",   32'(rx_has_data),   32'd0);
        chk("rst_data",  32'(rx_data),       32'd0);
        chk("rst_count", 32'(rx_count),      32'd0);
        chk("rst_uf",    32'(rx_underflow),  32'd0);
`ifdef RX_PARITY_EN
        chk("rst_perr",  32'(rx_parity_err), 32'd0);
`endif

        // Release: ready stays low until the first rising edge has passed.
        rst_n = 1'b1;
        #1;
        chk("rel_ready0", 32'(RX_Data_Ready), 32'd0);
        cyc();
        chk("rel_ready1", 32'(RX_Data_Ready), 32'd1);

        // Single word
        RX_Data = 8'hA5; RX_Data_Valid = 1'b1;
        cyc();
        RX_Data_Valid = 1'b0;
        chk("one_has",   32'(rx_has_data), 32'd1);
        chk("one_data",  32'(rx_data),     32'hA5);
        chk("one_count", 32'(rx_count),    32'd1);
        rc_took_data = 1'b1;
        cyc();
        rc_took_data = 1'b0;
        chk("one_pop_has",   32'(rx_has_data),  32'd0);
        chk("one_pop_count", 32'(rx_count),     32'd0);
        chk("one_pop_uf",    32'(rx_underflow), 32'd0);

        // Fill to full
        for (int i = 1; i <= 4; i++) begin
            RX_Data = 8'(i); RX_Data_Valid = 1'b1;
            cyc();
        end
        chk("full_count", 32'(rx_count),      32'd4);
        chk("full_ready", 32'(RX_Data_Ready), 32'd0);
        chk("full_head",  32'(rx_data),       32'h01);
        RX_Data = 8'h05;
        cyc();
        chk("held_count", 32'(rx_count), 32'd4);
        rc_took_data = 1'b1;
        cyc();
        rc_took_data = 1'b0;
        chk("pop1_count", 32'(rx_count),      32'd3);
        chk("pop1_ready", 32'(RX_Data_Ready), 32'd1);
        chk("pop1_head",  32'(rx_data),       32'h02);
        cyc();
        RX_Data_Valid = 1'b0;
        chk("acc5_count", 32'(rx_count), 32'd4);
        exp_q = '{8'h02, 8'h03, 8'h04, 8'h05};
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("drain%0d", i), 32'(rx_data), 32'(exp_q[i]));
            rc_took_data = 1'b1;
            cyc();
            rc_took_data = 1'b0;
        end
        chk("drain_count", 32'(rx_count),    32'd0);
        chk("drain_has",   32'(rx_has_data), 32'd0);

        // Simultaneous push and pop at count 2
        RX_Data_Valid = 1'b1;
        RX_Data = 8'h11; cyc();
        RX_Data = 8'h22; cyc();
        chk("sim_pre_count", 32'(rx_count), 32'd2);
        RX_Data = 8'h33; rc_took_data = 1'b1;
        cyc();
        RX_Data_Valid = 1'b0; rc_took_data = 1'b0;
        chk("sim_count", 32'(rx_count), 32'd2);
        chk("sim_head",  32'(rx_data),  32'h22);
        rc_took_data = 1'b1;
        cyc();
        chk("sim_next", 32'(rx_data),  32'h33);
        chk("sim_cnt1", 32'(rx_count), 32'd1);
        cyc();
        rc_took_data = 1'b0;
        chk("sim_empty", 32'(rx_count), 32'd0);
        chk("sim_no_uf", 32'(rx_underflow), 32'd0);

        // Underflow is sticky
        rc_took_data = 1'b1;
        cyc();
        rc_took_data = 1'b0;
        chk("uf_set",   32'(rx_underflow), 32'd1);
        chk("uf_count", 32'(rx_count),     32'd0);
        cyc(); cyc();
        chk("uf_stick", 32'(rx_underflow), 32'd1);

        // Reset with a word buffered discards it
        RX_Data = 8'h77; RX_Data_Valid = 1'b1;
        cyc();
        RX_Data_Valid = 1'b0;
        chk("mid_count", 32'(rx_count), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_count", 32'(rx_count),     32'd0);
        chk("mid_rst_uf",    32'(rx_underflow), 32'd0);
        chk("mid_rst_data",  32'(rx_data),      32'd0);
        cyc();
        rst_n = 1'b1;
        cyc();
        chk("rerun_ready", 32'(RX_Data_Ready), 32'd1);

`ifdef RX_PARITY_EN
        RX_Data = 8'h03; RX_Parity = 1'b1; RX_Data_Valid = 1'b1;
        cyc();
        RX_Data_Valid = 1'b0;
        chk("par_bad_err",   32'(rx_parity_err), 32'd1);
        chk("par_bad_count", 32'(rx_count),      32'd0);
        RX_Parity = 1'b0; RX_Data_Valid = 1'b1;
        cyc();
        RX_Data_Valid = 1'b0;
        chk("par_ok_count", 32'(rx_count), 32'd1);
        chk("par_ok_data",  32'(rx_data),  32'h03);
        chk("par_ok_err",   32'(rx_parity_err), 32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
